// File: rtl/find_min.sv
// Sequential minimum finder: captures N signed W-bit elements and scans one per cycle,
// presenting the smallest on result with a level done flag under a start handshake.
module find_min #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*W-1:0] numbers,
    output logic           done,
    output logic [W-1:0]   result
);

    localparam int unsigned IdxW = $clog2(N);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StScan,
        StDone
    } state_t;

    state_t          state;
    logic [N*W-1:0]  data_buf;
    logic [W-1:0]    cur_min;
    logic [IdxW-1:0] idx;

    logic [W-1:0]    elem;
    logic [W-1:0]    scan_min;

    always_comb begin
        elem     = data_buf[idx*W +: W];
        // Strict less-than keeps the earlier element on ties.
        scan_min = ($signed(elem) < $signed(cur_min)) ? elem : cur_min;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            done     <= 1'b0;
            result   <= '0;
            data_buf <= '0;
            cur_min  <= '0;
            idx      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // numbers is not sampled here; the source may update it on this edge.
                    if (start) state <= StLoad;
                end
                StLoad: begin
                    if (!start) begin
                        state <= StIdle;
                    end else begin
                        data_buf <= numbers;
                        cur_min  <= numbers[W-1:0];
                        idx      <= IdxW'(1);
                        state    <= StScan;
                    end
                end
                StScan: begin
                    if (!start) begin
                        state <= StIdle;
                    end else begin
                        cur_min <= scan_min;
                        idx     <= idx + IdxW'(1);
                        if (idx == IdxW'(N - 1)) begin
                            result <= scan_min;
                            done   <= 1'b1;
                            state  <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Holding start here does not retrigger; it must drop first.
                    if (!start) begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_find_min.sv
// Directed self-checking bench for find_min (N=8, W=16) using immediate assertions.
module tb_find_min;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] numbers;
    logic         done;
    logic [15:0]  result;

    int n_checks = 0;
    int n_fail   = 0;

    find_min #(
        .N(8),
        .W(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .numbers(numbers),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] pack8(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full request: done must stay low through E7 and rise at E8 with the minimum.
    task automatic run_op(input string tag, input logic [127:0] vec, input logic [15:0] exp);
        start   = 1'b1;
        numbers = vec;
        repeat (8) tick();
        check({tag, " done_low_E7"}, {31'd0, done}, 32'd0);
        tick();
        check({tag, " done_E8"}, {31'd0, done}, 32'd1);
        check({tag, " result"}, {16'd0, result}, {16'd0, exp});
    endtask

    task automatic release_op(input string tag, input logic [15:0] exp);
        start = 1'b0;
        tick();
        check({tag, " rel_done"}, {31'd0, done}, 32'd0);
        check({tag, " rel_result"}, {16'd0, result}, {16'd0, exp});
    endtask

    logic [127:0] v_mixed;
    logic [127:0] v_all8000;

    initial begin
        v_mixed   = pack8(16'h0010, 16'h0003, 16'h7FFF, 16'h0100,
                          16'h0007, 16'h0042, 16'h0005, 16'h0009);
        v_all8000 = pack8(16'h8000, 16'h8000, 16'h8000, 16'h8000,
                          16'h8000, 16'h8000, 16'h8000, 16'h8000);

        rst_n   = 1'b0;
        start   = 1'b0;
        numbers = '0;
        #12;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Mixed values, numbers valid only from one cycle after start.
        start   = 1'b1;
        numbers = v_all8000;
        tick();
        numbers = v_mixed;
        repeat (7) tick();
        check("mixed done_low_E7", {31'd0, done}, 32'd0);
        tick();
        check("mixed done_E8", {31'd0, done}, 32'd1);
        check("mixed result", {16'd0, result}, 32'h0003);

        // Start held in DONE: stable, no retrigger.
        numbers = v_all8000;
        repeat (12) tick();
        check("hold done", {31'd0, done}, 32'd1);
        check("hold result", {16'd0, result}, 32'h0003);
        release_op("mixed", 16'h0003);
        tick();
        check("idle done", {31'd0, done}, 32'd0);

        run_op("signed", pack8(16'h0001, 16'hFFFE, 16'h8000, 16'h0000,
                               16'h7FFF, 16'hFFFF, 16'h0002, 16'h0003), 16'h8000);
        release_op("signed", 16'h8000);
        run_op("signed_nomin", pack8(16'h0001, 16'hFFFE, 16'h0004, 16'h0000,
                                     16'h7FFF, 16'hFFFF, 16'h0002, 16'h0003), 16'hFFFE);
        release_op("signed_nomin", 16'hFFFE);

        run_op("min_at_0", pack8(16'h0001, 16'h0050, 16'h0050, 16'h0050,
                                 16'h0050, 16'h0050, 16'h0050, 16'h0050), 16'h0001);
        release_op("min_at_0", 16'h0001);
        run_op("min_at_7", pack8(16'h0050, 16'h0050, 16'h0050, 16'h0050,
                                 16'h0050, 16'h0050, 16'h0050, 16'h0001), 16'h0001);
        release_op("min_at_7", 16'h0001);
        run_op("all_equal", pack8(16'h1234, 16'h1234, 16'h1234, 16'h1234,
                                  16'h1234, 16'h1234, 16'h1234, 16'h1234), 16'h1234);
        release_op("all_equal", 16'h1234);

        // Abort during SCAN: done never rises, result keeps the previous value.
        start   = 1'b1;
        numbers = v_all8000;
        repeat (4) tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_scan done", {31'd0, done}, 32'd0);
        end
        check("abort_scan result", {16'd0, result}, 32'h1234);

        // Abort during LOAD, then a normal request must still work.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("abort_load done", {31'd0, done}, 32'd0);
        check("abort_load result", {16'd0, result}, 32'h1234);
        run_op("after_abort", v_mixed, 16'h0003);
        release_op("after_abort", 16'h0003);

        // Capture isolation: numbers changes after E1 must not matter.
        start   = 1'b1;
        numbers = v_mixed;
        repeat (2) tick();
        numbers = v_all8000;
        repeat (6) tick();
        check("isolate done_low_E7", {31'd0, done}, 32'd0);
        tick();
        check("isolate done_E8", {31'd0, done}, 32'd1);
        check("isolate result", {16'd0, result}, 32'h0003);
        release_op("isolate", 16'h0003);

        // Asynchronous reset mid-SCAN clears outputs without a clock edge.
        start   = 1'b1;
        numbers = v_all8000;
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        check("rst_scan done", {31'd0, done}, 32'd0);
        check("rst_scan result", {16'd0, result}, 32'd0);
        start = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while DONE is high.
        run_op("pre_rst", v_mixed, 16'h0003);
        rst_n = 1'b0;
        #2;
        check("rst_done done", {31'd0, done}, 32'd0);
        check("rst_done result", {16'd0, result}, 32'd0);
        start = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst idle done", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
